// File: rtl/vga_vsync_ctrl.sv
// rtl/vga_vsync_ctrl.sv - vertical timing generator: v_sync, h_sync_en gate, active line index, end-of-frame strobe
module vga_vsync_ctrl #(
  parameter int LINE_CYCLES = 1792,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 29,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic       v_sync,
  output logic       h_sync_en,
  output logic [9:0] v_line,
  output logic       frame_done
);

  localparam int V_TOTAL = V_PULSE + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [1:0] VS = 2'd0;
  localparam logic [1:0] VB = 2'd1;
  localparam logic [1:0] VA = 2'd2;
  localparam logic [1:0] VF = 2'd3;

  localparam logic [10:0] CYC_LAST = 11'(LINE_CYCLES - 1);
  localparam logic [9:0]  VS_END   = 10'(V_PULSE - 1);
  localparam logic [9:0]  VB_END   = 10'(V_PULSE + V_BACK - 1);
  localparam logic [9:0]  VA_END   = 10'(V_PULSE + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0]  LN_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  ACT_LAST = 10'(V_ACTIVE - 1);

  logic [10:0] cyc;
  logic [9:0]  ln;
  logic [9:0]  act;
  logic [1:0]  state;
  logic        line_end;

  assign line_end = (cyc == CYC_LAST);

  // Outputs decode the pre-edge counters, so they trail cyc/ln by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc        <= '0;
      ln         <= '0;
      act        <= '0;
      state      <= VS;
      v_sync     <= 1'b1;
      h_sync_en  <= 1'b0;
      v_line     <= '0;
      frame_done <= 1'b0;
    end else begin
      v_sync     <= (state != VS);
      h_sync_en  <= (state == VA);
      v_line     <= (state == VA) ? act : '0;
      frame_done <= (state == VA) && (act == ACT_LAST) && line_end;

      if (line_end) begin
        cyc <= '0;
        ln  <= (ln == LN_LAST) ? '0 : ln + 10'd1;
        case (state)
          VS: if (ln == VS_END) state <= VB;
          VB: if (ln == VB_END) state <= VA;
          VA: begin
            // act stays 0 outside VA so v_line restarts cleanly each frame
            if (ln == VA_END) begin
              state <= VF;
              act   <= '0;
            end else begin
              act <= act + 10'd1;
            end
          end
          VF: if (ln == LN_LAST) state <= VS;
          default: state <= VS;
        endcase
      end else begin
        cyc <= cyc + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_vsync_ctrl.sv
// tb/tb_vga_vsync_ctrl.sv - randomized self-checking bench for vga_vsync_ctrl against a frame-time model
module tb_vga_vsync_ctrl;

  localparam int L     = 16;
  localparam int VP    = 2;
  localparam int VB    = 3;
  localparam int VA    = 6;
  localparam int VF    = 2;
  localparam int FRAME = (VP + VB + VA + VF) * L;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v_sync;
  logic       h_sync_en;
  logic [9:0] v_line;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  int t = 0;
  int cyc_n = 0;
  int last_fall = -1;
  int fd_cnt = 0;
  logic prev_vs = 1'b1;
  int e_vs, e_en, e_vl, e_fd;

  vga_vsync_ctrl #(
    .LINE_CYCLES(L),
    .V_PULSE(VP),
    .V_BACK(VB),
    .V_ACTIVE(VA),
    .V_FRONT(VF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .v_sync(v_sync),
    .h_sync_en(h_sync_en),
    .v_line(v_line),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0d cycle=%0d)", tag, got, exp, t, cyc_n);
    end
  endtask

  // Expected outputs at frame-relative time tt, straight from the line/cycle rules.
  task automatic model(input int tt);
    int ln, cy;
    ln = tt / L;
    cy = tt % L;
    e_vs = (ln < VP) ? 0 : 1;
    e_en = (ln >= VP + VB && ln < VP + VB + VA) ? 1 : 0;
    e_vl = e_en ? ln - (VP + VB) : 0;
    e_fd = (e_en && e_vl == VA - 1 && cy == L - 1) ? 1 : 0;
  endtask

  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    if (!r) begin
      e_vs = 1; e_en = 0; e_vl = 0; e_fd = 0;
      t = 0;
    end else begin
      model(t);
      t = (t + 1) % FRAME;
    end
    @(negedge clk);
    check("v_sync", int'(v_sync), e_vs);
    check("h_sync_en", int'(h_sync_en), e_en);
    check("v_line", int'(v_line), e_vl);
    check("frame_done", int'(frame_done), e_fd);
    if (!r) begin
      last_fall = -1;
      fd_cnt = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (prev_vs && !v_sync) begin
        if (last_fall >= 0) begin
          check("frame_period", cyc_n - last_fall, FRAME);
          check("fd_per_frame", fd_cnt, 1);
        end
        last_fall = cyc_n;
        fd_cnt = 0;
      end
    end
    prev_vs = v_sync;
    cyc_n++;
  endtask

  initial begin
    repeat (3) step(1'b0);
    repeat (3 * FRAME + 40) step(1'b1);

    for (int i = 0; i < FRAME && t != 100; i++) step(1'b1);
    check("reach_va_point", t, 100);
    repeat (3) step(1'b0);
    repeat (FRAME + 20) step(1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        repeat ($urandom_range(1, 4)) step(1'b0);
      end else begin
        step(1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
